// File: rtl/clint_tmr_if.sv
// Data-side request/response handshake between a requester and the CLINT timer.
interface clint_tmr_if;
    logic        valid;
    logic        ready;
    logic [63:0] data_read;
    logic [63:0] data_write;
    logic [63:0] addr;
    logic [1:0]  size;
    logic [1:0]  resp;
    logic        req;

    modport master (
        output valid, data_write, addr, size, req,
        input  ready, data_read, resp
    );

    modport slave (
        input  valid, data_write, addr, size, req,
        output ready, data_read, resp
    );
endinterface

// File: rtl/clint_tmr.sv
// CLINT machine timer: free-running mtime, mtimecmp compare register and
// the machine timer interrupt, reachable through a fixed-latency slave port.
module clint_tmr #(
    parameter int unsigned TICK_DIV      = 1,
    parameter logic [63:0] MTIME_ADDR    = 64'h0000_0000_0200_bff8,
    parameter logic [63:0] MTIMECMP_ADDR = 64'h0000_0000_0200_4000
) (
    input  logic       clk,
    input  logic       rst,
    clint_tmr_if.slave bus,
    output logic       clint_tmr_mtip_o
);
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [63:0]   mtime;
    logic [63:0]   mtimecmp;
    logic [PW-1:0] presc;
    logic          tick;
    logic          accept;
    logic          hit_mtime;
    logic          hit_cmp;
    logic          misaligned;
    logic [7:0]    lane;
    logic [7:0]    strb;
    logic [63:0]   wmask;
    logic          ready_nxt;
    logic [63:0]   data_nxt;
    logic [1:0]    resp_nxt;
    logic          wr_mtime;
    logic          wr_cmp;

    assign tick = (presc == PW'(TICK_DIV - 1));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: accept in IDLE, respond for exactly one cycle
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (bus.valid) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Register decode, alignment check and byte-lane write mask of the offered request
    always_comb begin
        hit_mtime  = (bus.addr[63:3] == MTIME_ADDR[63:3]);
        hit_cmp    = (bus.addr[63:3] == MTIMECMP_ADDR[63:3]);
        misaligned = 1'b0;
        lane       = 8'h01;
        wmask      = '0;
        unique case (bus.size)
            2'b00: begin misaligned = 1'b0;             lane = 8'h01; end
            2'b01: begin misaligned = bus.addr[0];      lane = 8'h03; end
            2'b10: begin misaligned = |bus.addr[1:0];   lane = 8'h0F; end
            2'b11: begin misaligned = |bus.addr[2:0];   lane = 8'hFF; end
            default: begin misaligned = 1'b1;           lane = 8'h00; end
        endcase
        strb = lane << bus.addr[2:0];
        for (int b = 0; b < 8; b++) begin
            wmask[b*8 +: 8] = {8{strb[b]}};
        end
    end

    // Response and write-enable values loaded at the RESP-entry edge
    always_comb begin
        ready_nxt = 1'b0;
        data_nxt  = '0;
        resp_nxt  = RESP_OKAY;
        wr_mtime  = 1'b0;
        wr_cmp    = 1'b0;
        accept    = (state == IDLE) && bus.valid;
        if (accept) begin
            ready_nxt = 1'b1;
            if (!hit_mtime && !hit_cmp) begin
                resp_nxt = RESP_DECERR;
            end else if (misaligned) begin
                resp_nxt = RESP_SLVERR;
            end else if (bus.req) begin
                wr_mtime = hit_mtime;
                wr_cmp   = hit_cmp;
            end else begin
                data_nxt = hit_mtime ? mtime : mtimecmp;
            end
        end
    end

    // Timer registers, prescaler, interrupt and registered response
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.ready        <= 1'b0;
            bus.data_read    <= '0;
            bus.resp         <= RESP_OKAY;
            mtime            <= '0;
            mtimecmp         <= '1;
            presc            <= '0;
            clint_tmr_mtip_o <= 1'b0;
        end else begin
            bus.ready     <= ready_nxt;
            bus.data_read <= data_nxt;
            bus.resp      <= resp_nxt;
            presc         <= tick ? '0 : presc + PW'(1);
            if (wr_mtime) begin
                mtime <= (mtime & ~wmask) | (bus.data_write & wmask);
            end else if (tick) begin
                mtime <= mtime + 64'd1;
            end
            if (wr_cmp) begin
                mtimecmp <= (mtimecmp & ~wmask) | (bus.data_write & wmask);
            end
            clint_tmr_mtip_o <= (mtime >= mtimecmp);
        end
    end
endmodule

// File: tb/tb_clint_tmr.sv
// Bench for clint_tmr: two instances (TICK_DIV 1 and 4) against an arithmetic timer model.
module tb_clint_tmr;
    localparam logic [63:0] MT_A  = 64'h0000_0000_0200_bff8;
    localparam logic [63:0] CMP_A = 64'h0000_0000_0200_4000;
    localparam logic [63:0] BAD_A = 64'h0000_0000_0200_0000;
    localparam logic [63:0] ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    clint_tmr_if bus0 ();
    clint_tmr_if bus1 ();
    logic mtip0;
    logic mtip1;

    clint_tmr #(.TICK_DIV(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0), .clint_tmr_mtip_o(mtip0));
    clint_tmr #(.TICK_DIV(4)) dut1 (.clk(clk), .rst(rst), .bus(bus1), .clint_tmr_mtip_o(mtip1));

    // Edge index: 0 on the last reset edge, then 1, 2, ... afterwards
    int edge_n = 0;
    always @(posedge clk) begin
        if (rst) edge_n <= 0;
        else     edge_n <= edge_n + 1;
    end

    int checks = 0;
    int errors = 0;

    // Model: register value = last written value + number of ticks since that write
    int          td [2] = '{1, 4};
    logic [63:0] mt_base [2];
    logic [63:0] mt_old_base [2];
    int          mt_w [2];
    int          mt_old_w [2];
    logic [63:0] cmp_val [2];
    logic [63:0] cmp_old [2];
    int          cmp_w [2];

    logic [63:0] rd;
    logic [63:0] wd;
    int e, e1, e2, e3, w, rise;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Ticks occur on edges j with j % TICK_DIV == 0; count those in (a, b]
    function automatic logic [63:0] ticks(input int i, input int a, input int b);
        return 64'((b / td[i]) - (a / td[i]));
    endfunction

    function automatic logic [63:0] mt_after(input int i, input int n);
        if (n >= mt_w[i]) return mt_base[i] + ticks(i, mt_w[i], n);
        return mt_old_base[i] + ticks(i, mt_old_w[i], n);
    endfunction

    function automatic logic [63:0] cmp_after(input int i, input int n);
        return (n >= cmp_w[i]) ? cmp_val[i] : cmp_old[i];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mt_base[i] = '0; mt_old_base[i] = '0; mt_w[i] = 0; mt_old_w[i] = 0;
            cmp_val[i] = ONES; cmp_old[i] = ONES; cmp_w[i] = 0;
        end
    endtask

    function automatic logic get_ready(input int i);
        return (i == 0) ? bus0.ready : bus1.ready;
    endfunction
    function automatic logic [63:0] get_data(input int i);
        return (i == 0) ? bus0.data_read : bus1.data_read;
    endfunction
    function automatic logic [1:0] get_resp(input int i);
        return (i == 0) ? bus0.resp : bus1.resp;
    endfunction
    function automatic logic get_mtip(input int i);
        return (i == 0) ? mtip0 : mtip1;
    endfunction

    task automatic drive(input int i, input logic v, input logic wr, input logic [63:0] a,
                         input logic [1:0] sz, input logic [63:0] d);
        if (i == 0) begin
            bus0.valid = v; bus0.req = wr; bus0.addr = a; bus0.size = sz; bus0.data_write = d;
        end else begin
            bus1.valid = v; bus1.req = wr; bus1.addr = a; bus1.size = sz; bus1.data_write = d;
        end
    endtask

    task automatic set_valid(input int i, input logic v);
        if (i == 0) bus0.valid = v;
        else        bus1.valid = v;
    endtask

    // mtip during cycle n reflects the compare of the register values after edge n-1
    task automatic chk_mtip(input int i, input string tag);
        int   n;
        logic exp;
        n   = edge_n;
        exp = (n == 0) ? 1'b0 : (mt_after(i, n - 1) >= cmp_after(i, n - 1));
        check(tag, 64'(get_mtip(i)), 64'(exp));
    endtask

    // One request; returns the read data and the edge that sampled the request
    task automatic txn(input int i, input logic wr, input logic [63:0] a, input logic [1:0] sz,
                       input logic [63:0] d, input bit hold, output logic [63:0] rdata, output int se);
        logic [63:0] regv, mask, exp_d, merged;
        logic [1:0]  exp_r;
        bit          dec, mis, is_mt;
        int          off, nb;
        @(negedge clk);
        check("ready_idle", 64'(get_ready(i)), 64'd0);
        drive(i, 1'b1, wr, a, sz, d);
        @(posedge clk);
        #1;
        se    = edge_n;
        is_mt = ((a >> 3) == (MT_A >> 3));
        dec   = !is_mt && ((a >> 3) != (CMP_A >> 3));
        off   = int'(a & 64'd7);
        nb    = 1 << sz;
        mis   = (off % nb) != 0;
        regv  = is_mt ? mt_after(i, se - 1) : cmp_after(i, se - 1);
        exp_r = dec ? 2'b11 : (mis ? 2'b10 : 2'b00);
        exp_d = (!dec && !mis && !wr) ? regv : 64'd0;
        rdata = get_data(i);
        check("ready_pulse", 64'(get_ready(i)), 64'd1);
        check("resp", 64'(get_resp(i)), 64'(exp_r));
        check("data_read", rdata, exp_d);
        if (!dec && !mis && wr) begin
            mask = '0;
            for (int k = 0; k < 8; k++) begin
                if (k >= off && k < off + nb) mask |= (64'hFF << (8 * k));
            end
            merged = (regv & ~mask) | (d & mask);
            if (is_mt) begin
                mt_old_base[i] = mt_base[i]; mt_old_w[i] = mt_w[i];
                mt_base[i] = merged; mt_w[i] = se;
            end else begin
                cmp_old[i] = cmp_val[i]; cmp_val[i] = merged; cmp_w[i] = se;
            end
        end
        chk_mtip(i, "mtip_resp");
        if (!hold) set_valid(i, 1'b0);
        @(posedge clk);
        #1;
        check("ready_drop", 64'(get_ready(i)), 64'd0);
        check("resp_idle", 64'(get_resp(i)), 64'd0);
        check("data_idle", get_data(i), 64'd0);
        chk_mtip(i, "mtip_after");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int i, sel, gap;
        logic [63:0] base;
        logic [1:0]  sz;
        logic        wr;

        // Reset values
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 64'd0, 2'b00, 64'd0);
        drive(1, 1'b0, 1'b0, 64'd0, 2'b00, 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready0", 64'(bus0.ready), 64'd0);
        check("rst_data0", bus0.data_read, 64'd0);
        check("rst_resp0", 64'(bus0.resp), 64'd0);
        check("rst_mtip0", 64'(mtip0), 64'd0);
        check("rst_ready1", 64'(bus1.ready), 64'd0);
        check("rst_mtip1", 64'(mtip1), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Idle 10 cycles then read mtime: equals number of elapsed cycles
        repeat (10) @(posedge clk);
        txn(0, 1'b0, MT_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("mtime_elapsed", rd, 64'(e - 1));

        // mtimecmp = 40: mtip rises the cycle after mtime reaches 40
        while (edge_n < 18) begin @(posedge clk); #1; end
        txn(0, 1'b1, CMP_A, 2'b11, 64'd40, 1'b0, rd, w);
        rise = -1;
        while (edge_n < 46) begin
            @(posedge clk);
            #1;
            chk_mtip(0, "mtip_track");
            if (mtip0 && rise < 0) rise = edge_n;
        end
        check("mtip_rise_edge", 64'(rise), 64'd41);
        txn(0, 1'b1, CMP_A, 2'b11, ONES, 1'b0, rd, w);
        check("mtip_fall", 64'(mtip0), 64'd0);

        // Reset during a request drops it and restores register contents
        @(negedge clk);
        drive(0, 1'b1, 1'b1, CMP_A, 2'b11, 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_drop_ready", 64'(bus0.ready), 64'd0);
        @(negedge clk);
        set_valid(0, 1'b0);
        rst = 1'b0;
        model_reset();
        txn(0, 1'b0, CMP_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("rst_cmp", rd, ONES);

        // Byte write into lane 5 of mtimecmp
        txn(0, 1'b1, CMP_A + 64'd5, 2'b00, 64'h0000_AB00_0000_0000, 1'b0, rd, e);
        txn(0, 1'b0, CMP_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("byte_merge", rd, 64'hFFFF_ABFF_FFFF_FFFF);

        // Misaligned and undecoded accesses
        txn(0, 1'b0, MT_A + 64'd2, 2'b10, 64'd0, 1'b0, rd, e);
        check("misalign_data", rd, 64'd0);
        txn(0, 1'b0, BAD_A, 2'b11, 64'd0, 1'b0, rd, e);
        txn(0, 1'b1, CMP_A + 64'd1, 2'b01, 64'h1234_5678_9ABC_DEF0, 1'b0, rd, e);
        txn(0, 1'b0, CMP_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("misalign_nowrite", rd, 64'hFFFF_ABFF_FFFF_FFFF);

        // TICK_DIV=4: write all-ones on a tick edge, write wins, wrap on next tick
        while (((edge_n + 1) % 4) != 0) begin @(posedge clk); #1; end
        txn(1, 1'b1, MT_A, 2'b11, ONES, 1'b0, rd, w);
        txn(1, 1'b0, MT_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("write_wins", rd, ONES);
        txn(1, 1'b0, MT_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("pre_wrap", rd, ONES);
        txn(1, 1'b0, MT_A, 2'b11, 64'd0, 1'b0, rd, e);
        check("wrap_zero", rd, 64'd0);

        // Back-to-back read, write, read with valid held
        wd = {$urandom, $urandom};
        txn(0, 1'b0, CMP_A, 2'b11, 64'd0, 1'b1, rd, e1);
        txn(0, 1'b1, CMP_A, 2'b11, wd, 1'b1, rd, e2);
        txn(0, 1'b0, CMP_A, 2'b11, 64'd0, 1'b0, rd, e3);
        check("b2b_gap1", 64'(e2 - e1), 64'd2);
        check("b2b_gap2", 64'(e3 - e2), 64'd2);
        check("b2b_read", rd, wd);

        // Randomized traffic on both instances
        for (int t = 0; t < 60; t++) begin
            i   = int'($urandom_range(0, 1));
            sel = int'($urandom_range(0, 4));
            base = (sel < 2) ? MT_A : ((sel < 4) ? CMP_A : BAD_A);
            sz  = 2'($urandom_range(0, 3));
            wr  = 1'($urandom_range(0, 1));
            wd  = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} : 64'($urandom_range(0, 300));
            txn(i, wr, base + 64'($urandom_range(0, 7)), sz, wd, 1'b0, rd, e);
            gap = int'($urandom_range(0, 2));
            repeat (gap) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
